// File: rtl/instr_decode_issue_pkg.sv
// Shared opcode encoding, instruction field positions and opcode classifiers
// for the decode/issue stage.
package instr_decode_issue_pkg;

    typedef enum logic [4:0] {
        OP_NOT  = 5'd0,
        OP_AND  = 5'd1,
        OP_OR   = 5'd2,
        OP_XOR  = 5'd3,
        OP_ADD  = 5'd4,
        OP_SUB  = 5'd5,
        OP_MUL  = 5'd6,
        OP_DIV  = 5'd7,
        OP_INC  = 5'd8,
        OP_DEC  = 5'd9,
        OP_JMP  = 5'd12,
        OP_BEQ  = 5'd13,
        OP_BNE  = 5'd14,
        OP_CALL = 5'd15,
        OP_RET  = 5'd16,
        OP_LD   = 5'd17,
        OP_ST   = 5'd18,
        OP_FFT  = 5'd19,
        OP_ENC  = 5'd20,
        OP_DCR  = 5'd21
    } opcode_e;

    typedef enum logic [2:0] {
        UNIT_ALU = 3'd0,
        UNIT_MDU = 3'd1,
        UNIT_BRU = 3'd2,
        UNIT_LSU = 3'd3,
        UNIT_SPU = 3'd4
    } unit_e;

    localparam int OP_HI   = 18;
    localparam int OP_LO   = 14;
    localparam int FA_HI   = 13;
    localparam int FA_LO   = 11;
    localparam int FB_HI   = 10;
    localparam int FB_LO   = 8;
    localparam int FC_HI   = 7;
    localparam int FC_LO   = 5;
    localparam int IMM8_HI = 7;
    localparam int ADDR_HI = 13;

    typedef struct packed {
        logic [4:0] op;
        logic [2:0] rd;
        logic [2:0] rs1;
        logic [2:0] rs2;
        unit_e      unit;
        logic       we;
        logic       mem_rd;
        logic       mem_wr;
        logic       jump;
    } ctrl_t;

    function automatic logic is_mc(input logic [4:0] op);
        return op inside {OP_MUL, OP_DIV, OP_FFT, OP_ENC, OP_DCR};
    endfunction

    function automatic logic is_legal(input logic [4:0] op);
        return !(op inside {5'b01010, 5'b01011, [5'b10110:5'b11111]});
    endfunction

endpackage

// File: rtl/instr_decode_issue_ras.sv
// Circular return-address stack; a push into a full stack overwrites the
// oldest entry, and both overflow and underflow raise a one-cycle err pulse.
module ret_addr_stack #(
    parameter int RAS_DEPTH = 4,
    parameter int XLEN      = 19
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] push_data,
    output logic [XLEN-1:0] top,
    output logic            empty,
    output logic            err
);
    localparam int PW = $clog2(RAS_DEPTH);

    logic [XLEN-1:0] mem_q [RAS_DEPTH];
    logic [PW-1:0]   wp_q;
    logic [PW-1:0]   top_idx;
    logic [PW:0]     cnt_q;
    logic            err_q;
    logic            full;

    assign top_idx = wp_q - PW'(1);
    assign top     = mem_q[top_idx];
    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == (PW+1)'(RAS_DEPTH));
    assign err     = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RAS_DEPTH; i++) mem_q[i] <= '0;
            wp_q  <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (push) begin
                // When full, wp_q already points at the oldest slot.
                mem_q[wp_q] <= push_data;
                wp_q        <= wp_q + PW'(1);
                if (full) err_q <= 1'b1;
                else      cnt_q <= cnt_q + 1'b1;
            end else if (pop) begin
                if (empty) begin
                    err_q <= 1'b1;
                end else begin
                    wp_q  <= top_idx;
                    cnt_q <= cnt_q - 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/instr_decode_issue.sv
// Decode/issue stage: decodes fetch words into a registered control bundle,
// issues it over valid/ready, stalls on multi-cycle units and resolves CALL/RET.
module instr_decode_issue
    import instr_decode_issue_pkg::*;
#(
    parameter int RAS_DEPTH = 4,
    parameter int XLEN      = 19
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      out_op,
    output logic [2:0]      out_rd,
    output logic [2:0]      out_rs1,
    output logic [2:0]      out_rs2,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_unit,
    output logic            out_we,
    output logic            out_mem_rd,
    output logic            out_mem_wr,
    output logic            out_jump,
    output logic [XLEN-1:0] out_target,
    input  logic            mc_done,
    output logic            busy,
    output logic            illegal,
    output logic            ras_err
);

    typedef enum logic [1:0] {S_EMPTY, S_FULL, S_MCWAIT} state_e;

    state_e          state_q;
    ctrl_t           ctrl_q, dec_ctrl;
    logic [XLEN-1:0] imm_q, tgt_q, link_q;
    logic [XLEN-1:0] dec_imm, dec_tgt, sext8, pc_inc;
    logic [4:0]      dec_op;
    logic            illegal_q;
    logic            accept, load, fire;
    logic            ras_push, ras_pop, ras_empty, ras_err_w;
    logic [XLEN-1:0] ras_top;

    assign dec_op = in_instr[OP_HI:OP_LO];
    assign sext8  = {{(XLEN-8){in_instr[IMM8_HI]}}, in_instr[IMM8_HI:0]};
    assign pc_inc = in_pc + XLEN'(1);

    always_comb begin
        dec_ctrl      = '0;
        dec_ctrl.op   = dec_op;
        dec_ctrl.unit = UNIT_ALU;
        dec_imm       = '0;
        dec_tgt       = '0;
        case (dec_op)
            OP_NOT, OP_AND, OP_OR, OP_XOR, OP_ADD, OP_SUB, OP_INC, OP_DEC,
            OP_MUL, OP_DIV, OP_FFT, OP_ENC, OP_DCR: begin
                dec_ctrl.rd  = in_instr[FA_HI:FA_LO];
                dec_ctrl.rs1 = in_instr[FB_HI:FB_LO];
                dec_ctrl.rs2 = in_instr[FC_HI:FC_LO];
                dec_ctrl.we  = 1'b1;
                if (dec_op inside {OP_MUL, OP_DIV})               dec_ctrl.unit = UNIT_MDU;
                else if (dec_op inside {OP_FFT, OP_ENC, OP_DCR})  dec_ctrl.unit = UNIT_SPU;
            end
            OP_LD, OP_ST: begin
                dec_ctrl.rd     = in_instr[FA_HI:FA_LO];
                dec_ctrl.rs1    = in_instr[FB_HI:FB_LO];
                dec_ctrl.unit   = UNIT_LSU;
                dec_ctrl.we     = (dec_op == OP_LD);
                dec_ctrl.mem_rd = (dec_op == OP_LD);
                dec_ctrl.mem_wr = (dec_op == OP_ST);
                dec_imm         = sext8;
            end
            OP_BEQ, OP_BNE: begin
                dec_ctrl.rs1  = in_instr[FA_HI:FA_LO];
                dec_ctrl.rs2  = in_instr[FB_HI:FB_LO];
                dec_ctrl.unit = UNIT_BRU;
                dec_imm       = sext8;
                dec_tgt       = pc_inc + sext8;
            end
            OP_JMP, OP_CALL: begin
                dec_ctrl.unit = UNIT_BRU;
                dec_ctrl.jump = 1'b1;
                dec_tgt       = {{(XLEN-14){1'b0}}, in_instr[ADDR_HI:0]};
            end
            OP_RET: begin
                dec_ctrl.unit = UNIT_BRU;
                dec_ctrl.jump = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        case (state_q)
            S_EMPTY: in_ready = !flush;
            S_FULL:  in_ready = out_ready && !is_mc(ctrl_q.op) && !flush;
            default: in_ready = 1'b0;
        endcase
    end

    // A flushed bundle never counts as issued, so a dropped CALL cannot push.
    assign fire   = (state_q == S_FULL) && out_ready && !flush;
    assign accept = in_valid && in_ready;
    assign load   = accept && is_legal(dec_op);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_EMPTY;
            ctrl_q    <= '0;
            imm_q     <= '0;
            tgt_q     <= '0;
            link_q    <= '0;
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= accept && !is_legal(dec_op);
            if (load) begin
                ctrl_q <= dec_ctrl;
                imm_q  <= dec_imm;
                tgt_q  <= dec_tgt;
                link_q <= pc_inc;
            end
            case (state_q)
                S_EMPTY: if (load) state_q <= S_FULL;
                S_FULL: begin
                    if (flush)                 state_q <= S_EMPTY;
                    else if (out_ready) begin
                        if (is_mc(ctrl_q.op))  state_q <= S_MCWAIT;
                        else if (load)         state_q <= S_FULL;
                        else                   state_q <= S_EMPTY;
                    end
                end
                S_MCWAIT: if (mc_done) state_q <= S_EMPTY;
                default: state_q <= S_EMPTY;
            endcase
        end
    end

    assign ras_push = fire && (ctrl_q.op == OP_CALL);
    assign ras_pop  = fire && (ctrl_q.op == OP_RET);

    ret_addr_stack #(
        .RAS_DEPTH (RAS_DEPTH),
        .XLEN      (XLEN)
    ) u_ras (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (link_q),
        .top       (ras_top),
        .empty     (ras_empty),
        .err       (ras_err_w)
    );

    assign out_valid  = (state_q == S_FULL);
    assign busy       = (state_q != S_EMPTY);
    assign illegal    = illegal_q;
    assign ras_err    = ras_err_w;
    assign out_op     = ctrl_q.op;
    assign out_rd     = ctrl_q.rd;
    assign out_rs1    = ctrl_q.rs1;
    assign out_rs2    = ctrl_q.rs2;
    assign out_imm    = imm_q;
    assign out_unit   = ctrl_q.unit;
    assign out_we     = ctrl_q.we;
    assign out_mem_rd = ctrl_q.mem_rd;
    assign out_mem_wr = ctrl_q.mem_wr;
    assign out_jump   = ctrl_q.jump;
    // RET reads the stack live so a CALL issued just ahead of it is visible.
    assign out_target = (state_q == S_FULL && ctrl_q.op == OP_RET)
                        ? (ras_empty ? '0 : ras_top) : tgt_q;

endmodule

// File: tb/tb_instr_decode_issue.sv
// Directed bench for instr_decode_issue: issue, stalls, branches, RAS, flush, reset.
module tb_instr_decode_issue;

    localparam logic [4:0] ADD = 5'd4, SUB = 5'd5, MUL = 5'd6, DIV = 5'd7,
                           JMP = 5'd12, BEQ = 5'd13, BNE = 5'd14, CALL = 5'd15,
                           RET = 5'd16, LD = 5'd17;

    logic        clk = 0, rst_n = 0, flush = 0, in_valid = 0, out_ready = 0, mc_done = 0;
    logic [18:0] in_instr = '0, in_pc = '0;
    logic        in_ready, out_valid, out_we, out_mem_rd, out_mem_wr, out_jump;
    logic        busy, illegal, ras_err;
    logic [4:0]  out_op;
    logic [2:0]  out_rd, out_rs1, out_rs2, out_unit;
    logic [18:0] out_imm, out_target;
    int checks = 0, failures = 0;

    instr_decode_issue #(.RAS_DEPTH(4), .XLEN(19)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_op(out_op), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_imm(out_imm), .out_unit(out_unit), .out_we(out_we), .out_mem_rd(out_mem_rd),
        .out_mem_wr(out_mem_wr), .out_jump(out_jump), .out_target(out_target),
        .mc_done(mc_done), .busy(busy), .illegal(illegal), .ras_err(ras_err)
    );

    always #5 clk = ~clk;

    function automatic logic [18:0] rtype(input logic [4:0] op, input logic [2:0] a, b, c);
        return {op, a, b, c, 5'b0};
    endfunction
    function automatic logic [18:0] itype(input logic [4:0] op, input logic [2:0] a, b,
                                          input logic [7:0] imm);
        return {op, a, b, imm};
    endfunction
    function automatic logic [18:0] jtype(input logic [4:0] op, input logic [13:0] addr);
        return {op, addr};
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0h exp=1", in_ready); end
        checks++; if ({out_valid, busy, illegal, ras_err} !== 4'b0) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {out_valid, busy, illegal, ras_err}); end
        checks++; if ({out_op, out_rd, out_rs1, out_rs2, out_unit, out_we, out_mem_rd, out_mem_wr, out_jump} !== '0) begin
            failures++; $display("FAIL reset_bundle got=nonzero exp=0"); end
        checks++; if ({out_imm, out_target} !== '0) begin failures++; $display("FAIL reset_imm_tgt got=%h/%h exp=0", out_imm, out_target); end
        tick(); tick();
        rst_n = 1;
    endtask

    task automatic test_back_to_back();
        logic [18:0] vec   [3];
        logic [4:0]  e_op  [3];
        logic [2:0]  e_rd  [3], e_rs1 [3], e_rs2 [3], e_unit [3];
        vec[0] = rtype(ADD, 3'd1, 3'd2, 3'd3); e_op[0] = ADD; e_rd[0] = 1; e_rs1[0] = 2; e_rs2[0] = 3; e_unit[0] = 0;
        vec[1] = rtype(SUB, 3'd4, 3'd5, 3'd6); e_op[1] = SUB; e_rd[1] = 4; e_rs1[1] = 5; e_rs2[1] = 6; e_unit[1] = 0;
        vec[2] = itype(LD,  3'd7, 3'd1, 8'h80); e_op[2] = LD; e_rd[2] = 7; e_rs1[2] = 1; e_rs2[2] = 0; e_unit[2] = 3;
        out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1; in_instr = vec[i]; in_pc = 19'h10 + 19'(i);
            #1;
            checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_in_ready[%0d] got=%0h exp=1", i, in_ready); end
            tick();
            checks++; if (out_valid !== 1'b1 || out_op !== e_op[i] || out_we !== 1'b1 || out_unit !== e_unit[i]) begin
                failures++; $display("FAIL b2b_ctrl[%0d] got=v%0h op%0d we%0h u%0d exp=v1 op%0d we1 u%0d", i, out_valid, out_op, out_we, out_unit, e_op[i], e_unit[i]); end
            checks++; if ({out_rd, out_rs1, out_rs2} !== {e_rd[i], e_rs1[i], e_rs2[i]}) begin
                failures++; $display("FAIL b2b_regs[%0d] got=%0d,%0d,%0d exp=%0d,%0d,%0d", i, out_rd, out_rs1, out_rs2, e_rd[i], e_rs1[i], e_rs2[i]); end
        end
        checks++; if (out_imm !== 19'h7FF80 || out_mem_rd !== 1'b1) begin failures++; $display("FAIL ld_imm got=%h/%0h exp=7ff80/1", out_imm, out_mem_rd); end
        in_valid = 0;
        tick();
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%0h/%0h exp=0/0", out_valid, busy); end
    endtask

    task automatic test_mc_stall();
        out_ready = 1; in_valid = 1; in_instr = rtype(MUL, 3'd1, 3'd2, 3'd3); in_pc = 19'h20;
        tick();
        checks++; if (out_valid !== 1'b1 || out_unit !== 3'd1 || in_ready !== 1'b0) begin
            failures++; $display("FAIL mul_full got=v%0h u%0d r%0h exp=v1 u1 r0", out_valid, out_unit, in_ready); end
        in_instr = rtype(ADD, 3'd2, 3'd3, 3'd4); in_pc = 19'h21;
        tick();
        checks++; if (out_valid !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b0) begin
            failures++; $display("FAIL mcwait_entry got=v%0h b%0h r%0h exp=v0 b1 r0", out_valid, busy, in_ready); end
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL mcwait_ready[%0d] got=%0h exp=0", k, in_ready); end
        end
        mc_done = 1; #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL mcdone_cycle_ready got=%0h exp=0", in_ready); end
        tick();
        mc_done = 0; #1;
        checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL after_mcdone got=r%0h b%0h exp=r1 b0", in_ready, busy); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_op !== ADD || out_rd !== 3'd2) begin
            failures++; $display("FAIL post_mc_issue got=v%0h op%0d rd%0d exp=v1 op4 rd2", out_valid, out_op, out_rd); end
        in_valid = 0; tick();
    endtask

    task automatic test_branch();
        out_ready = 0; in_valid = 1; in_instr = itype(BEQ, 3'd1, 3'd2, 8'hFE); in_pc = 19'h7FFFF;
        tick();
        checks++; if (out_target !== 19'h7FFFE || out_imm !== 19'h7FFFE) begin
            failures++; $display("FAIL beq_target got=%h/%h exp=7fffe/7fffe", out_target, out_imm); end
        checks++; if (out_unit !== 3'd2 || out_we !== 1'b0 || out_jump !== 1'b0 || out_rs1 !== 3'd1 || out_rs2 !== 3'd2) begin
            failures++; $display("FAIL beq_ctrl got=u%0d we%0h j%0h rs%0d,%0d exp=u2 we0 j0 rs1,2", out_unit, out_we, out_jump, out_rs1, out_rs2); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL full_stall_ready got=%0h exp=0", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_op !== BEQ) begin failures++; $display("FAIL beq_hold got=v%0h op%0d exp=v1 op13", out_valid, out_op); end
        out_ready = 1; in_instr = itype(BNE, 3'd3, 3'd4, 8'h01);
        tick();
        checks++; if (out_op !== BNE || out_target !== 19'h00001) begin
            failures++; $display("FAIL bne_wrap got=op%0d t%h exp=op14 t00001", out_op, out_target); end
        in_valid = 0; tick();
    endtask

    task automatic test_call_ret();
        out_ready = 1; in_valid = 1; in_instr = jtype(CALL, 14'h1234); in_pc = 19'h40;
        tick();
        checks++; if (out_target !== 19'h01234 || out_jump !== 1'b1 || out_we !== 1'b0) begin
            failures++; $display("FAIL call_decode got=t%h j%0h we%0h exp=t01234 j1 we0", out_target, out_jump, out_we); end
        in_instr = jtype(RET, 14'h0); in_pc = 19'h1234;
        tick();
        checks++; if (out_op !== RET || out_target !== 19'h00041) begin
            failures++; $display("FAIL ret_target got=op%0d t%h exp=op16 t00041", out_op, out_target); end
        in_valid = 0; tick();
        checks++; if (ras_err !== 1'b0) begin failures++; $display("FAIL ret_pop_err got=%0h exp=0", ras_err); end
    endtask

    task automatic test_ras_overflow();
        logic [18:0] exp_t [5];
        exp_t[0] = 19'h105; exp_t[1] = 19'h104; exp_t[2] = 19'h103; exp_t[3] = 19'h102; exp_t[4] = 19'h0;
        out_ready = 1; in_valid = 1;
        for (int i = 0; i < 5; i++) begin
            in_instr = jtype(CALL, 14'(i)); in_pc = 19'h100 + 19'(i);
            tick();
            checks++; if (ras_err !== 1'b0) begin failures++; $display("FAIL call_no_err[%0d] got=%0h exp=0", i, ras_err); end
        end
        in_instr = jtype(RET, 14'h0);
        for (int j = 0; j < 5; j++) begin
            tick();
            checks++; if (out_valid !== 1'b1 || out_target !== exp_t[j]) begin
                failures++; $display("FAIL ret_seq[%0d] got=v%0h t%h exp=v1 t%h", j, out_valid, out_target, exp_t[j]); end
            checks++; if (ras_err !== (j == 0)) begin failures++; $display("FAIL ras_err_seq[%0d] got=%0h exp=%0h", j, ras_err, j == 0); end
        end
        in_valid = 0;
        tick();
        checks++; if (ras_err !== 1'b1 || out_valid !== 1'b0) begin
            failures++; $display("FAIL ret_underflow got=e%0h v%0h exp=e1 v0", ras_err, out_valid); end
        tick();
        checks++; if (ras_err !== 1'b0) begin failures++; $display("FAIL ras_err_pulse got=%0h exp=0", ras_err); end
    endtask

    task automatic test_flush();
        out_ready = 0; in_valid = 1; in_instr = jtype(CALL, 14'h55); in_pc = 19'h200;
        tick();
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL flush_pre got=%0h exp=1", out_valid); end
        flush = 1; in_instr = rtype(ADD, 3'd1, 3'd1, 3'd1); #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_ready got=%0h exp=0", in_ready); end
        tick();
        flush = 0; in_valid = 0;
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL flush_empty got=v%0h b%0h exp=0/0", out_valid, busy); end
        out_ready = 1; in_valid = 1; in_instr = jtype(RET, 14'h0);
        tick();
        checks++; if (out_valid !== 1'b1 || out_target !== 19'h0) begin
            failures++; $display("FAIL flush_no_push got=v%0h t%h exp=v1 t0", out_valid, out_target); end
        in_valid = 0;
        tick();
        checks++; if (ras_err !== 1'b1) begin failures++; $display("FAIL flush_ret_err got=%0h exp=1", ras_err); end
    endtask

    task automatic test_illegal();
        logic [4:0] codes [3];
        codes[0] = 5'b01010; codes[1] = 5'b10110; codes[2] = 5'b11111;
        out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1; in_instr = {codes[i], 14'h0};
            tick();
            checks++; if (illegal !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
                failures++; $display("FAIL illegal[%0d] got=i%0h v%0h b%0h exp=i1 v0 b0", i, illegal, out_valid, busy); end
        end
        in_valid = 0;
        tick();
        checks++; if (illegal !== 1'b0) begin failures++; $display("FAIL illegal_pulse got=%0h exp=0", illegal); end
    endtask

    task automatic test_reset_mcwait();
        out_ready = 1; in_valid = 1; in_instr = rtype(DIV, 3'd5, 3'd6, 3'd7); in_pc = 19'h300;
        tick();
        in_valid = 0;
        tick();
        checks++; if (busy !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL div_mcwait got=b%0h v%0h exp=b1 v0", busy, out_valid); end
        tick();
        #2 rst_n = 0; #1;
        checks++; if ({busy, out_valid, illegal, ras_err} !== 4'b0 || out_op !== 5'd0 || out_rd !== 3'd0 || out_unit !== 3'd0 || out_we !== 1'b0) begin
            failures++; $display("FAIL async_reset got=b%0h v%0h op%0d rd%0d u%0d exp=0", busy, out_valid, out_op, out_rd, out_unit); end
        tick();
        rst_n = 1; #1;
        checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL post_reset got=r%0h b%0h exp=r1 b0", in_ready, busy); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_mc_stall();
        test_branch();
        test_call_ret();
        test_ras_overflow();
        test_flush();
        test_illegal();
        test_reset_mcwait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
